// File: rtl/h80cpu_uart_tx_if.sv
`default_nettype none
// ============================================================================
//  Module   : h80cpu_uart_tx_if
//  Purpose  : h80cpu I/O bus port bundle (run/done toggle handshake).
//  Revision : 1.0  initial release
// ============================================================================
interface h80cpu_uart_tx_if;
  logic [15:0] addr;
  logic [2:0]  cmd;
  logic        run;
  logic [15:0] wr_data;
  logic [15:0] rd_data;
  logic        done;

  modport master (
    output addr, cmd, run, wr_data,
    input  rd_data, done
  );

  modport slave (
    input  addr, cmd, run, wr_data,
    output rd_data, done
  );
endinterface
`default_nettype wire

// File: rtl/h80cpu_uart_tx.sv
`default_nettype none
// ============================================================================
//  Module   : h80cpu_uart_tx
//  Purpose  : I/O-bus UART transmitter with TX FIFO, 8N1 LSB first.
//             Define H80CPU_UART_TX_PARITY_EN to append an even parity bit.
//  Revision : 1.0  initial release
// ============================================================================
module h80cpu_uart_tx #(
  parameter int CLK_FREQ   = 27000000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 8
) (
  input  wire logic       clk,
  input  wire logic       reset,
  h80cpu_uart_tx_if.slave bus,
  output logic            uart_txp
);

  localparam int c_BIT_CYCLES = CLK_FREQ / BAUD;
  localparam int c_CNT_W      = $clog2(c_BIT_CYCLES);
  localparam int c_PTR_W      = $clog2(FIFO_DEPTH);

  localparam logic [c_CNT_W-1:0] c_CNT_LOAD    = c_CNT_W'(c_BIT_CYCLES - 1);
  localparam logic [c_PTR_W:0]   c_COUNT_FULL  = (c_PTR_W + 1)'(FIFO_DEPTH);
  localparam logic [2:0]         c_CMD_WRITE_W = 3'd2;
  localparam logic [2:0]         c_CMD_WRITE_B = 3'd3;
  localparam logic [7:0]         c_ADDR_TXDATA = 8'h00;
  localparam logic [7:0]         c_ADDR_STATUS = 8'h02;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
`ifdef H80CPU_UART_TX_PARITY_EN
    S_PARITY = 3'd3,
`endif
    S_STOP   = 3'd4
  } state_t;

  // FIFO storage and pointers
  logic [7:0]         r_mem [FIFO_DEPTH];
  logic [c_PTR_W-1:0] r_wr_ptr;
  logic [c_PTR_W-1:0] r_rd_ptr;
  logic [c_PTR_W:0]   r_count;

  // bus side
  logic        r_done;
  logic [15:0] r_rd_data;
  logic        w_pending;
  logic        w_is_write;
  logic        w_hit_tx;
  logic        w_hit_status;
  logic        w_stall;
  logic        w_service;
  logic        w_push;
  logic        w_full;
  logic        w_empty;
  logic        w_busy;
  logic [15:0] w_status;
  logic        w_unused_bits;

  // transmitter
  state_t             r_state;
  state_t             w_state_nxt;
  logic [c_CNT_W-1:0] r_bit_cnt;
  logic [c_CNT_W-1:0] w_bit_cnt_nxt;
  logic [2:0]         r_bit_idx;
  logic [2:0]         w_bit_idx_nxt;
  logic [7:0]         r_shift;
  logic [7:0]         w_shift_nxt;
  logic               r_txp;
  logic               w_txp;
  logic               w_pop;
`ifdef H80CPU_UART_TX_PARITY_EN
  logic               r_parity;
  logic               w_parity_nxt;
`endif

  assign w_full   = (r_count == c_COUNT_FULL);
  assign w_empty  = (r_count == '0);
  assign w_busy   = (r_state != S_IDLE) || !w_empty;
  assign w_status = {13'b0, w_busy, w_empty, w_full};

  assign w_pending    = bus.run ^ r_done;
  assign w_is_write   = (bus.cmd == c_CMD_WRITE_W) || (bus.cmd == c_CMD_WRITE_B);
  assign w_hit_tx     = (bus.addr[7:0] == c_ADDR_TXDATA);
  assign w_hit_status = (bus.addr[7:0] == c_ADDR_STATUS);
  // Fullness is judged on the pre-edge count, so a same-edge pop cannot admit the write.
  assign w_stall      = w_is_write && w_hit_tx && w_full;
  assign w_service    = w_pending && !w_stall;
  assign w_push       = w_service && w_is_write && w_hit_tx;

  assign w_unused_bits = &{1'b0, bus.addr[15:8], bus.wr_data[15:8]};

  assign bus.done    = r_done;
  assign bus.rd_data = r_rd_data;
  assign uart_txp    = r_txp;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_done    <= 1'b0;
      r_rd_data <= 16'h0000;
    end else if (w_service) begin
      r_done    <= ~r_done;
      r_rd_data <= (!w_is_write && w_hit_status) ? w_status : 16'h0000;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= bus.wr_data[7:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      r_count <= r_count + (c_PTR_W + 1)'(w_push) - (c_PTR_W + 1)'(w_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_bit_cnt <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
      r_txp     <= 1'b1;
`ifdef H80CPU_UART_TX_PARITY_EN
      r_parity  <= 1'b0;
`endif
    end else begin
      r_state   <= w_state_nxt;
      r_bit_cnt <= w_bit_cnt_nxt;
      r_bit_idx <= w_bit_idx_nxt;
      r_shift   <= w_shift_nxt;
      r_txp     <= w_txp;
`ifdef H80CPU_UART_TX_PARITY_EN
      r_parity  <= w_parity_nxt;
`endif
    end
  end

  // Line level is the current state's output registered once, hence the 1-clk lag after a pop.
  always_comb begin
    w_state_nxt   = r_state;
    w_bit_cnt_nxt = r_bit_cnt;
    w_bit_idx_nxt = r_bit_idx;
    w_shift_nxt   = r_shift;
    w_pop         = 1'b0;
    w_txp         = 1'b1;
`ifdef H80CPU_UART_TX_PARITY_EN
    w_parity_nxt  = r_parity;
`endif
    case (r_state)
      S_IDLE: begin
        if (!w_empty) begin
          w_pop         = 1'b1;
          w_shift_nxt   = r_mem[r_rd_ptr];
          w_bit_cnt_nxt = c_CNT_LOAD;
          w_state_nxt   = S_START;
`ifdef H80CPU_UART_TX_PARITY_EN
          w_parity_nxt  = ^r_mem[r_rd_ptr];
`endif
        end
      end
      S_START: begin
        w_txp = 1'b0;
        if (r_bit_cnt == '0) begin
          w_bit_cnt_nxt = c_CNT_LOAD;
          w_bit_idx_nxt = 3'd0;
          w_state_nxt   = S_DATA;
        end else begin
          w_bit_cnt_nxt = r_bit_cnt - 1'b1;
        end
      end
      S_DATA: begin
        w_txp = r_shift[0];
        if (r_bit_cnt == '0) begin
          w_bit_cnt_nxt = c_CNT_LOAD;
          w_shift_nxt   = {1'b0, r_shift[7:1]};
          if (r_bit_idx == 3'd7) begin
`ifdef H80CPU_UART_TX_PARITY_EN
            w_state_nxt = S_PARITY;
`else
            w_state_nxt = S_STOP;
`endif
          end else begin
            w_bit_idx_nxt = r_bit_idx + 1'b1;
          end
        end else begin
          w_bit_cnt_nxt = r_bit_cnt - 1'b1;
        end
      end
`ifdef H80CPU_UART_TX_PARITY_EN
      S_PARITY: begin
        w_txp = r_parity;
        if (r_bit_cnt == '0) begin
          w_bit_cnt_nxt = c_CNT_LOAD;
          w_state_nxt   = S_STOP;
        end else begin
          w_bit_cnt_nxt = r_bit_cnt - 1'b1;
        end
      end
`endif
      S_STOP: begin
        w_txp = 1'b1;
        if (r_bit_cnt == '0) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_bit_cnt_nxt = r_bit_cnt - 1'b1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_h80cpu_uart_tx.sv
`default_nettype none
// ============================================================================
//  Module   : tb_h80cpu_uart_tx
//  Purpose  : Scoreboard bench: bus replies and serial frames vs. reference queues.
//  Revision : 1.0  initial release
// ============================================================================
module tb_h80cpu_uart_tx;

  localparam int c_BIT = 8;
`ifdef H80CPU_UART_TX_PARITY_EN
  localparam int c_NBITS = 9;
`else
  localparam int c_NBITS = 8;
`endif
  localparam int c_FRAME   = (c_NBITS + 2) * c_BIT + 1;
  localparam int c_TIMEOUT = 400;
  localparam logic [2:0] c_RD_W = 3'd0;
  localparam logic [2:0] c_RD_B = 3'd1;
  localparam logic [2:0] c_WR_W = 3'd2;
  localparam logic [2:0] c_WR_B = 3'd3;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic uart_txp;

  h80cpu_uart_tx_if bus ();

  h80cpu_uart_tx #(
    .CLK_FREQ  (8),
    .BAUD      (1),
    .FIFO_DEPTH(4)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus),
    .uart_txp(uart_txp)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit          is_read;
    logic [15:0] data;
  } bus_exp_t;

  bus_exp_t   bus_q[$];
  logic [7:0] ser_q[$];
  int         start_times[$];
  int         frames_done = 0;
  int         reset_epoch = 0;
  int         n_checks = 0;
  int         n_pass = 0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endfunction

  function automatic void fail_now(string name, string what);
    n_checks++;
    $display("FAIL %s: %s", name, what);
  endfunction

  task automatic finish_run();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  endtask

`ifdef H80CPU_UART_TX_PARITY_EN
  function automatic logic even_parity(logic [7:0] b);
    int ones = 0;
    for (int i = 0; i < 8; i++) if (b[i]) ones++;
    return (ones % 2) == 1;
  endfunction
`endif

  // Issue one bus request; the reference expectation is queued before the toggle.
  task automatic bus_xfer(input logic [2:0] c, input logic [15:0] a, input logic [15:0] d,
                          input logic [15:0] exp_rd, input int min_lat, input int max_lat,
                          output int t_issue);
    bus_exp_t e;
    bit       is_wr;
    int       lat;
    is_wr = (c == c_WR_W) || (c == c_WR_B);
    @(negedge clk);
    bus.cmd     = c;
    bus.addr    = a;
    bus.wr_data = d;
    e.is_read   = !is_wr;
    e.data      = exp_rd;
    bus_q.push_back(e);
    if (is_wr && a[7:0] == 8'h00) ser_q.push_back(d[7:0]);
    t_issue = cyc;
    bus.run = ~bus.run;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (bus.done !== bus.run && lat < c_TIMEOUT);
    if (bus.done !== bus.run) begin
      fail_now("bus_timeout", $sformatf("addr %0h never completed", a));
      finish_run();
    end else if (lat < min_lat || lat > max_lat) begin
      fail_now("bus_latency", $sformatf("addr %0h got %0d clks, expected %0d..%0d",
                                        a, lat, min_lat, max_lat));
    end else begin
      n_checks++;
      n_pass++;
    end
  endtask

  task automatic wait_frames(input int target);
    int k = 0;
    while (frames_done < target && k < 20 * c_FRAME) begin
      @(negedge clk);
      k++;
    end
    if (frames_done < target) begin
      fail_now("frame_timeout", $sformatf("got %0d frames, expected %0d", frames_done, target));
      finish_run();
    end
  endtask

  // Bus monitor: every done toggle retires the oldest outstanding request.
  initial begin
    logic prev;
    bus_exp_t e;
    prev = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (reset) begin
        prev = bus.done;
      end else if (bus.done !== prev) begin
        prev = bus.done;
        if (bus_q.size() == 0) begin
          fail_now("spurious_done", "done toggled with no request outstanding");
        end else begin
          e = bus_q.pop_front();
          if (e.is_read) check("rd_data", {16'h0, bus.rd_data}, {16'h0, e.data});
        end
      end
    end
  end

  // Serial monitor: mid-bit sampling of each frame, compared against the byte queue.
  initial begin
    forever begin
      int         t0;
      int         ep;
      logic [8:0] bits;
      logic       start_b;
      logic       stop_b;
      logic [7:0] exp_b;
      @(posedge clk);
      #1;
      if (!reset && uart_txp === 1'b0) begin
        t0 = cyc;
        ep = reset_epoch;
        bits = '0;
        start_times.push_back(t0);
        repeat (c_BIT / 2) @(posedge clk);
        #1;
        start_b = uart_txp;
        for (int i = 0; i < c_NBITS; i++) begin
          repeat (c_BIT) @(posedge clk);
          #1;
          bits[i] = uart_txp;
        end
        repeat (c_BIT) @(posedge clk);
        #1;
        stop_b = uart_txp;
        if (reset_epoch == ep) begin
          check("start_bit", {31'h0, start_b}, 32'h0);
          check("stop_bit", {31'h0, stop_b}, 32'h1);
          if (ser_q.size() == 0) begin
            fail_now("unexpected_frame", $sformatf("byte %0h sent with nothing queued", bits[7:0]));
          end else begin
            exp_b = ser_q.pop_front();
            check("tx_byte", {24'h0, bits[7:0]}, {24'h0, exp_b});
`ifdef H80CPU_UART_TX_PARITY_EN
            check("parity_bit", {31'h0, bits[8]}, {31'h0, even_parity(exp_b)});
`endif
            frames_done++;
          end
        end
      end
    end
  end

  initial begin
    #2000000;
    fail_now("watchdog", "simulation time limit reached");
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    int t55;
    int highs;
    int ns0;
    int nstart;
    int fd;
    int target;
    int r;
    logic [7:0] b;
    logic [7:0] a8;

    bus.run     = 1'b0;
    bus.cmd     = c_RD_W;
    bus.addr    = 16'h0;
    bus.wr_data = 16'h0;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // idle after reset
    highs = 0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (uart_txp === 1'b1) highs++;
    end
    check("idle_line_high", highs, 20);
    check("done_after_reset", {31'h0, bus.done}, 32'h0);
    check("rd_data_after_reset", {16'h0, bus.rd_data}, 32'h0);
    bus_xfer(c_RD_W, 16'h0002, 16'h0, 16'h0002, 1, 1, t);

    // 0x55 then A1..A4 fill the FIFO while 0x55 is on the line
    bus_xfer(c_WR_B, 16'h0000, 16'h0055, 16'h0, 1, 1, t55);
    for (int i = 0; i < 4; i++) begin
      b = 8'hA1 + 8'(i);
      bus_xfer((i % 2 == 0) ? c_WR_W : c_WR_B, 16'h0000, {8'($urandom), b}, 16'h0, 1, 1, t);
    end
    repeat (12) @(negedge clk);
    bus_xfer(c_RD_B, 16'h0002, 16'h0, 16'h0005, 1, 1, t);
    bus_xfer(c_WR_B, 16'h0000, 16'h00A5, 16'h0, 2, 200, t);
    wait_frames(6);
    check("first_start_latency", start_times[0] - t55, 3);
    for (int i = 1; i < 6; i++) begin
      check("frame_spacing", start_times[i] - start_times[i-1], c_FRAME);
    end
    repeat (10) @(negedge clk);
    bus_xfer(c_RD_W, 16'h0002, 16'h0, 16'h0002, 1, 1, t);

    // reset mid-frame drops the frame and everything queued behind it
    ns0 = start_times.size();
    bus_xfer(c_WR_B, 16'h0000, 16'h0000, 16'h0, 1, 1, t);
    bus_xfer(c_WR_B, 16'h0000, 16'h0011, 16'h0, 1, 1, t);
    bus_xfer(c_WR_B, 16'h0000, 16'h0022, 16'h0, 1, 1, t);
    r = 0;
    while (start_times.size() == ns0 && r < 50) begin
      @(negedge clk);
      r++;
    end
    if (start_times.size() == ns0) begin
      fail_now("start_timeout", "0x00 frame never started");
      finish_run();
    end
    t = start_times[ns0];
    while (cyc < t + 29) @(negedge clk);
    reset = 1'b1;
    bus.run = 1'b0;
    reset_epoch++;
    ser_q.delete();
    bus_q.delete();
    @(posedge clk);
    #1;
    check("txp_high_on_reset", {31'h0, uart_txp}, 32'h1);
    @(negedge clk);
    reset = 1'b0;
    bus_xfer(c_RD_W, 16'h0002, 16'h0, 16'h0002, 1, 1, t);
    nstart = start_times.size();
    fd = frames_done;
    repeat (300) @(negedge clk);
    check("no_starts_after_reset", start_times.size(), nstart);
    check("no_frames_after_reset", frames_done, fd);

    // 0x07, plus unmapped accesses that must not transmit
    target = frames_done + 1;
    ns0 = start_times.size();
    bus_xfer(c_WR_B, 16'h0000, 16'h0007, 16'h0, 1, 1, t);
    bus_xfer(c_RD_W, 16'h0010, 16'h0, 16'h0000, 1, 1, t);
    bus_xfer(c_WR_W, 16'h0010, 16'h0099, 16'h0, 1, 1, t);
    wait_frames(target);
    repeat (3 * c_FRAME) @(negedge clk);
    check("unmapped_write_not_sent", start_times.size(), ns0 + 1);
    bus_xfer(c_RD_W, 16'h0002, 16'h0, 16'h0002, 1, 1, t);

    // randomized traffic
    target = frames_done;
    for (int i = 0; i < 16; i++) begin
      r = $urandom_range(0, 3);
      case (r)
        0, 1: begin
          bus_xfer($urandom_range(0, 1) ? c_WR_W : c_WR_B, {8'($urandom), 8'h00},
                   16'($urandom), 16'h0, 1, 200, t);
          target++;
        end
        2: begin
          case ($urandom_range(0, 3))
            0: a8 = 8'h00;
            1: a8 = 8'h10;
            2: a8 = 8'hFF;
            default: a8 = 8'h01;
          endcase
          bus_xfer($urandom_range(0, 1) ? c_RD_W : c_RD_B, {8'($urandom), a8},
                   16'h0, 16'h0000, 1, 1, t);
        end
        default: begin
          a8 = $urandom_range(0, 1) ? 8'h02 : 8'h10;
          bus_xfer(c_WR_B, {8'($urandom), a8}, 16'($urandom), 16'h0, 1, 1, t);
        end
      endcase
      repeat ($urandom_range(0, 20)) @(negedge clk);
    end
    wait_frames(target);
    repeat (12) @(negedge clk);
    bus_xfer(c_RD_B, 16'h0002, 16'h0, 16'h0002, 1, 1, t);
    repeat (4) @(negedge clk);
    check("bus_queue_drained", bus_q.size(), 0);
    check("serial_queue_drained", ser_q.size(), 0);
    finish_run();
  end

endmodule
`default_nettype wire
